// File: rtl/rf_wb_queue_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_queue_pkg
// Shared definitions for the register-file write-back queue:
//   - register index width and register count
//   - load size encodings
//   - payload record stored per load-return queue entry
// ---------------------------------------------------------------------------
package rf_wb_queue_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned NUM_REGS  = 1 << REG_IDX_W;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    LDSZ_BYTE = 2'b00,
    LDSZ_HALF = 2'b01,
    LDSZ_WORD = 2'b10,
    LDSZ_ILL  = 2'b11
  } ld_size_e;

  // Payload of one queued load; the valid bit lives in a separate vector so
  // it can be reset while the payload storage is not.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [3:0]           wen;
    logic [DATA_W-1:0]    data;
  } ldq_entry_t;

endpackage

// File: rtl/rf_lane_align.sv
// ---------------------------------------------------------------------------
// rf_lane_align
// Purely combinational lane placement and byte-enable generation for a
// right-justified load return.
//   size_i     : load size (byte / half / word / illegal)
//   offset_i   : byte address bits [1:0]
//   data_i     : right-justified load data
//   wen_o      : per-byte write enables for the register file
//   din_o      : data placed on the lanes selected by wen_o
//   misalign_o : alignment violation or illegal size; wen_o is zero then
// ---------------------------------------------------------------------------
module rf_lane_align
  import rf_wb_queue_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [3:0]        wen_o,
  output logic [DATA_W-1:0] din_o,
  output logic              misalign_o
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; that is what keeps combinational logic latch-free.
  always_comb begin
    wen_o      = 4'h0;
    din_o      = data_i;
    misalign_o = 1'b0;
    case (ld_size_e'(size_i))
      // Replicating the item onto every lane puts it on the target lane
      // whatever the offset; lanes outside wen_o are ignored by the file.
      LDSZ_BYTE: begin
        din_o = {4{data_i[7:0]}};
        wen_o = 4'b0001 << offset_i;
      end
      LDSZ_HALF: begin
        din_o = {2{data_i[15:0]}};
        if (offset_i[0]) misalign_o = 1'b1;
        else             wen_o = offset_i[1] ? 4'hC : 4'h3;
      end
      LDSZ_WORD: begin
        if (offset_i != 2'b00) misalign_o = 1'b1;
        else                   wen_o = 4'hF;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_wb_queue.sv
// ---------------------------------------------------------------------------
// rf_wb_queue
// Register-file write-back arbiter. ALU results always win the single write
// port; load returns are written directly when the path is free (bypass) or
// parked in a small FIFO and drained in order. A younger ALU write to the
// same register kills any older pending load to it (WAW).
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clk_en          global stall; low freezes all state and outputs
//   i_alu_*           ALU write request (valid / rd / data), always accepted
//   i_ld_*            load return (valid / rd / data / size / offset)
//   o_ld_ready        load handshake ready (queue not full)
//   o_waddr/o_wen/o_din/o_cs_b  registered register-file write port
//   o_pend_mask       per-register flag: a live load still targets it
//   o_ld_misalign     one-cycle pulse for a dropped misaligned/illegal load
// ---------------------------------------------------------------------------
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clk_en,
  input  logic                 i_alu_valid,
  input  logic [REG_IDX_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0]    i_alu_data,
  input  logic                 i_ld_valid,
  input  logic [REG_IDX_W-1:0] i_ld_rd,
  input  logic [DATA_W-1:0]    i_ld_data,
  input  logic [1:0]           i_ld_size,
  input  logic [1:0]           i_ld_offset,
  output logic                 o_ld_ready,
  output logic [REG_IDX_W-1:0] o_waddr,
  output logic [3:0]           o_wen,
  output logic [DATA_W-1:0]    o_din,
  output logic                 o_cs_b,
  output logic [NUM_REGS-1:0]  o_pend_mask,
  output logic                 o_ld_misalign
);

  localparam int unsigned PTR_W = $clog2(LDQ_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(LDQ_DEPTH);

  // Queue state
  logic [LDQ_DEPTH-1:0] valid_q, valid_d;
  ldq_entry_t           ent_q [LDQ_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;

  // Write port and status registers
  logic                 cs_b_q, cs_b_d;
  logic [3:0]           wen_q, wen_d;
  logic [REG_IDX_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic                 pres_ld_q, pres_ld_d;   // presented write is a load
  logic                 misalign_q, misalign_d;

  // Aligned view of the incoming load
  logic [3:0]        al_wen;
  logic [DATA_W-1:0] al_din;
  logic              al_misalign;

  rf_lane_align u_align (
    .size_i     (i_ld_size),
    .offset_i   (i_ld_offset),
    .data_i     (i_ld_data),
    .wen_o      (al_wen),
    .din_o      (al_din),
    .misalign_o (al_misalign)
  );

  logic full, empty, ld_fire, ld_ok, alu_hit_ld;
  logic head_live, head_dead, bypass, push, pop_wr, pop;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign o_ld_ready = !full;

  assign ld_fire    = i_ld_valid && o_ld_ready && i_clk_en;
  assign ld_ok      = ld_fire && !al_misalign;
  assign alu_hit_ld = i_alu_valid && (i_alu_rd == i_ld_rd);

  // A killed head is retired without a write, even in ALU cycles, so dead
  // entries never block the queue.
  assign head_live  = !empty && valid_q[head_q];
  assign head_dead  = !empty && !valid_q[head_q];
  assign pop_wr     = !i_alu_valid && head_live;
  assign pop        = pop_wr || head_dead;
  assign bypass     = ld_ok && !i_alu_valid && empty;
  // A load arriving alongside an ALU write to the same rd is already stale.
  assign push       = ld_ok && !bypass && !alu_hit_ld;

  // Write-port selection: ALU, else queue head, else bypass.
  always_comb begin
    cs_b_d    = 1'b1;
    wen_d     = 4'h0;
    waddr_d   = waddr_q;
    din_d     = din_q;
    pres_ld_d = 1'b0;
    if (i_alu_valid) begin
      cs_b_d  = 1'b0;
      wen_d   = 4'hF;
      waddr_d = i_alu_rd;
      din_d   = i_alu_data;
    end else if (pop_wr) begin
      cs_b_d    = 1'b0;
      wen_d     = ent_q[head_q].wen;
      waddr_d   = ent_q[head_q].rd;
      din_d     = ent_q[head_q].data;
      pres_ld_d = 1'b1;
    end else if (bypass) begin
      cs_b_d    = 1'b0;
      wen_d     = al_wen;
      waddr_d   = i_ld_rd;
      din_d     = al_din;
      pres_ld_d = 1'b1;
    end
  end

  // Queue bookkeeping: WAW kill, then pop, then push.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (i_alu_valid && valid_q[i] && (ent_q[i].rd == i_alu_rd))
        valid_d[i] = 1'b0;
    end
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    misalign_d = ld_fire && al_misalign;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cs_b_q     <= 1'b1;
      wen_q      <= 4'h0;
      waddr_q    <= '0;
      din_q      <= '0;
      pres_ld_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else if (i_clk_en) begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cs_b_q     <= cs_b_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      pres_ld_q  <= pres_ld_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: payload storage has no reset; the reset valid bits alone decide
  // whether an entry means anything.
  always_ff @(posedge i_clk) begin
    if (i_clk_en && push) begin
      ent_q[tail_q] <= '{rd: i_ld_rd, wen: al_wen, data: al_din};
    end
  end

  // Pending mask: live queue entries plus a load currently on the port.
  always_comb begin
    o_pend_mask = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (valid_q[i]) o_pend_mask[ent_q[i].rd] = 1'b1;
    end
    if (pres_ld_q) o_pend_mask[waddr_q] = 1'b1;
  end

  assign o_cs_b        = cs_b_q;
  assign o_wen         = wen_q;
  assign o_waddr       = waddr_q;
  assign o_din         = din_q;
  assign o_ld_misalign = misalign_q;

endmodule

// File: tb/tb_rf_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_queue
// Directed, table-driven bench for rf_wb_queue plus hand-written sequences
// for queue fill/drain, WAW kill, stall and reset-with-full-queue.
// ---------------------------------------------------------------------------
module tb_rf_wb_queue;

  logic        i_clk = 1'b0;
  logic        i_rst, i_clk_en;
  logic        i_alu_valid;
  logic [3:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_ld_valid;
  logic [3:0]  i_ld_rd;
  logic [31:0] i_ld_data;
  logic [1:0]  i_ld_size, i_ld_offset;
  logic        o_ld_ready;
  logic [3:0]  o_waddr, o_wen;
  logic [31:0] o_din;
  logic        o_cs_b;
  logic [15:0] o_pend_mask;
  logic        o_ld_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_queue #(.LDQ_DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clk_en      (i_clk_en),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .i_ld_valid    (i_ld_valid),
    .i_ld_rd       (i_ld_rd),
    .i_ld_data     (i_ld_data),
    .i_ld_size     (i_ld_size),
    .i_ld_offset   (i_ld_offset),
    .o_ld_ready    (o_ld_ready),
    .o_waddr       (o_waddr),
    .o_wen         (o_wen),
    .o_din         (o_din),
    .o_cs_b        (o_cs_b),
    .o_pend_mask   (o_pend_mask),
    .o_ld_misalign (o_ld_misalign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        alu_v;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_v;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        exp_cs_b;
    logic [3:0]  exp_wen;
    logic [3:0]  exp_waddr;
    logic [31:0] exp_din;
    logic        exp_mis;
    logic [15:0] exp_pend;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] wen);
    lane_mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction

  // Advance one clock; outputs are sampled and inputs changed 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [3:0] rd, input logic [31:0] d);
    i_alu_valid = v;
    i_alu_rd    = rd;
    i_alu_data  = d;
  endtask

  task automatic set_ld(input logic v, input logic [3:0] rd, input logic [31:0] d,
                        input logic [1:0] sz, input logic [1:0] off);
    i_ld_valid  = v;
    i_ld_rd     = rd;
    i_ld_data   = d;
    i_ld_size   = sz;
    i_ld_offset = off;
  endtask

  task automatic idle();
    set_alu(1'b0, 4'd0, 32'h0);
    set_ld(1'b0, 4'd0, 32'h0, 2'b00, 2'b00);
  endtask

  task automatic check_write(input string tag, input logic [3:0] wen,
                             input logic [3:0] addr, input logic [31:0] din);
    check({tag, ".cs_b"},  {31'h0, o_cs_b}, 32'h0);
    check({tag, ".wen"},   {28'h0, o_wen}, {28'h0, wen});
    check({tag, ".waddr"}, {28'h0, o_waddr}, {28'h0, addr});
    check({tag, ".din"},   o_din & lane_mask(wen), din & lane_mask(wen));
  endtask

  task automatic check_nowrite(input string tag);
    check({tag, ".cs_b"}, {31'h0, o_cs_b}, 32'h1);
    check({tag, ".wen"},  {28'h0, o_wen}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{"alu_rd3",     1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0,  32'h0,        2'b00, 2'b00,
                 1'b0, 4'hF, 4'd3,  32'hDEADBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{"ld_b_off2",   1'b0, 4'd0,  32'h0,        1'b1, 4'd5,  32'h000000AB, 2'b00, 2'b10,
                 1'b0, 4'h4, 4'd5,  32'h00AB0000, 1'b0, 16'h0020};
    vecs[2]  = '{"ld_b_off0",   1'b0, 4'd0,  32'h0,        1'b1, 4'd1,  32'h00000012, 2'b00, 2'b00,
                 1'b0, 4'h1, 4'd1,  32'h00000012, 1'b0, 16'h0002};
    vecs[3]  = '{"ld_b_off3",   1'b0, 4'd0,  32'h0,        1'b1, 4'd2,  32'h00000034, 2'b00, 2'b11,
                 1'b0, 4'h8, 4'd2,  32'h34000000, 1'b0, 16'h0004};
    vecs[4]  = '{"ld_h_off0",   1'b0, 4'd0,  32'h0,        1'b1, 4'd6,  32'h0000BEEF, 2'b01, 2'b00,
                 1'b0, 4'h3, 4'd6,  32'h0000BEEF, 1'b0, 16'h0040};
    vecs[5]  = '{"ld_h_off2",   1'b0, 4'd0,  32'h0,        1'b1, 4'd8,  32'h0000CAFE, 2'b01, 2'b10,
                 1'b0, 4'hC, 4'd8,  32'hCAFE0000, 1'b0, 16'h0100};
    vecs[6]  = '{"ld_w_off0",   1'b0, 4'd0,  32'h0,        1'b1, 4'd9,  32'h12345678, 2'b10, 2'b00,
                 1'b0, 4'hF, 4'd9,  32'h12345678, 1'b0, 16'h0200};
    vecs[7]  = '{"ld_h_off1",   1'b0, 4'd0,  32'h0,        1'b1, 4'd10, 32'h00001234, 2'b01, 2'b01,
                 1'b1, 4'h0, 4'd0,  32'h0,        1'b1, 16'h0000};
    vecs[8]  = '{"ld_w_off2",   1'b0, 4'd0,  32'h0,        1'b1, 4'd11, 32'h11112222, 2'b10, 2'b10,
                 1'b1, 4'h0, 4'd0,  32'h0,        1'b1, 16'h0000};
    vecs[9]  = '{"ld_sz11",     1'b0, 4'd0,  32'h0,        1'b1, 4'd12, 32'h00000055, 2'b11, 2'b00,
                 1'b1, 4'h0, 4'd0,  32'h0,        1'b1, 16'h0000};
    vecs[10] = '{"alu_kill_byp", 1'b1, 4'd4, 32'h55AA55AA, 1'b1, 4'd4,  32'h00000099, 2'b10, 2'b00,
                 1'b0, 4'hF, 4'd4,  32'h55AA55AA, 1'b0, 16'h0000};

    // ---------------- reset ----------------
    i_rst = 1'b1;
    i_clk_en = 1'b1;
    idle();
    tick();
    tick();
    check("rst.cs_b",     {31'h0, o_cs_b}, 32'h1);
    check("rst.wen",      {28'h0, o_wen}, 32'h0);
    check("rst.waddr",    {28'h0, o_waddr}, 32'h0);
    check("rst.din",      o_din, 32'h0);
    check("rst.pend",     {16'h0, o_pend_mask}, 32'h0);
    check("rst.misalign", {31'h0, o_ld_misalign}, 32'h0);
    check("rst.ready",    {31'h0, o_ld_ready}, 32'h1);
    i_rst = 1'b0;
    tick();

    // ---------------- single-transaction vectors ----------------
    for (int v = 0; v < 11; v++) begin
      check({vecs[v].name, ".ready_in"}, {31'h0, o_ld_ready}, 32'h1);
      set_alu(vecs[v].alu_v, vecs[v].alu_rd, vecs[v].alu_data);
      set_ld(vecs[v].ld_v, vecs[v].ld_rd, vecs[v].ld_data, vecs[v].sz, vecs[v].off);
      tick();
      idle();
      check({vecs[v].name, ".cs_b"}, {31'h0, o_cs_b}, {31'h0, vecs[v].exp_cs_b});
      check({vecs[v].name, ".wen"}, {28'h0, o_wen}, {28'h0, vecs[v].exp_wen});
      if (!vecs[v].exp_cs_b) begin
        check({vecs[v].name, ".waddr"}, {28'h0, o_waddr}, {28'h0, vecs[v].exp_waddr});
        check({vecs[v].name, ".din"}, o_din & lane_mask(vecs[v].exp_wen),
              vecs[v].exp_din & lane_mask(vecs[v].exp_wen));
      end
      check({vecs[v].name, ".misalign"}, {31'h0, o_ld_misalign}, {31'h0, vecs[v].exp_mis});
      check({vecs[v].name, ".pend"}, {16'h0, o_pend_mask}, {16'h0, vecs[v].exp_pend});
      check({vecs[v].name, ".ready"}, {31'h0, o_ld_ready}, 32'h1);
      // Nothing may remain queued and the misalign pulse lasts one cycle.
      tick();
      check({vecs[v].name, ".after_cs_b"}, {31'h0, o_cs_b}, 32'h1);
      check({vecs[v].name, ".after_mis"}, {31'h0, o_ld_misalign}, 32'h0);
      check({vecs[v].name, ".after_pend"}, {16'h0, o_pend_mask}, 32'h0);
    end

    // ---------------- ALU burst with loads: fill, backpressure, drain ----------------
    set_alu(1'b1, 4'd10, 32'hA0A0A0A0);
    set_ld(1'b1, 4'd11, 32'h00000111, 2'b10, 2'b00);
    tick();
    check_write("burst0", 4'hF, 4'd10, 32'hA0A0A0A0);
    check("burst0.pend", {16'h0, o_pend_mask}, 32'h0800);
    check("burst0.ready", {31'h0, o_ld_ready}, 32'h1);
    set_alu(1'b1, 4'd12, 32'hA1A1A1A1);
    set_ld(1'b1, 4'd13, 32'h00000222, 2'b10, 2'b00);
    tick();
    check_write("burst1", 4'hF, 4'd12, 32'hA1A1A1A1);
    check("burst1.pend", {16'h0, o_pend_mask}, 32'h2800);
    check("burst1.ready", {31'h0, o_ld_ready}, 32'h0);
    set_alu(1'b1, 4'd14, 32'hA2A2A2A2);
    set_ld(1'b1, 4'd15, 32'h00000333, 2'b10, 2'b00);
    tick();
    check_write("burst2", 4'hF, 4'd14, 32'hA2A2A2A2);
    check("burst2.ready", {31'h0, o_ld_ready}, 32'h0);
    set_alu(1'b1, 4'd1, 32'hA3A3A3A3);
    tick();
    check_write("burst3", 4'hF, 4'd1, 32'hA3A3A3A3);
    check("burst3.ready", {31'h0, o_ld_ready}, 32'h0);
    check("burst3.pend", {16'h0, o_pend_mask}, 32'h2800);
    idle();
    tick();
    check_write("drain_a", 4'hF, 4'd11, 32'h00000111);
    check("drain_a.pend", {16'h0, o_pend_mask}, 32'h2800);
    tick();
    check_write("drain_b", 4'hF, 4'd13, 32'h00000222);
    check("drain_b.pend", {16'h0, o_pend_mask}, 32'h2000);
    tick();
    check_nowrite("drain_end");
    check("drain_end.pend", {16'h0, o_pend_mask}, 32'h0);
    check("drain_end.ready", {31'h0, o_ld_ready}, 32'h1);

    // ---------------- WAW kill of a queued load ----------------
    set_alu(1'b1, 4'd2, 32'h22222222);
    set_ld(1'b1, 4'd7, 32'h00000777, 2'b10, 2'b00);
    tick();
    check("waw_q.pend", {16'h0, o_pend_mask}, 32'h0080);
    set_alu(1'b1, 4'd7, 32'h70707070);
    set_ld(1'b0, 4'd0, 32'h0, 2'b00, 2'b00);
    tick();
    idle();
    check_write("waw_alu", 4'hF, 4'd7, 32'h70707070);
    check("waw_alu.pend", {16'h0, o_pend_mask}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_nowrite($sformatf("waw_after%0d", k));
      check($sformatf("waw_after%0d.pend", k), {16'h0, o_pend_mask}, 32'h0);
    end
    check("waw_after.ready", {31'h0, o_ld_ready}, 32'h1);

    // ---------------- stall holds everything ----------------
    set_alu(1'b1, 4'd2, 32'h0000C0DE);
    set_ld(1'b1, 4'd9, 32'h00000999, 2'b10, 2'b00);
    tick();
    i_clk_en = 1'b0;
    set_alu(1'b1, 4'd3, 32'h33333333);
    set_ld(1'b1, 4'd1, 32'h00000001, 2'b11, 2'b00);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_write($sformatf("stall%0d", k), 4'hF, 4'd2, 32'h0000C0DE);
      check($sformatf("stall%0d.pend", k), {16'h0, o_pend_mask}, 32'h0200);
      check($sformatf("stall%0d.mis", k), {31'h0, o_ld_misalign}, 32'h0);
    end
    i_clk_en = 1'b1;
    idle();
    tick();
    check_write("unstall", 4'hF, 4'd9, 32'h00000999);
    check("unstall.pend", {16'h0, o_pend_mask}, 32'h0200);
    tick();
    check_nowrite("unstall_end");
    check("unstall_end.pend", {16'h0, o_pend_mask}, 32'h0);

    // ---------------- reset with a full queue while stalled ----------------
    set_alu(1'b1, 4'd1, 32'h11111111);
    set_ld(1'b1, 4'd5, 32'h00000005, 2'b10, 2'b00);
    tick();
    set_alu(1'b1, 4'd2, 32'h22222222);
    set_ld(1'b1, 4'd6, 32'h00000006, 2'b10, 2'b00);
    tick();
    check("full.ready", {31'h0, o_ld_ready}, 32'h0);
    check("full.pend", {16'h0, o_pend_mask}, 32'h0060);
    idle();
    i_clk_en = 1'b0;
    i_rst = 1'b1;
    tick();
    check_nowrite("rstfull");
    check("rstfull.pend", {16'h0, o_pend_mask}, 32'h0);
    check("rstfull.ready", {31'h0, o_ld_ready}, 32'h1);
    check("rstfull.waddr", {28'h0, o_waddr}, 32'h0);
    i_rst = 1'b0;
    i_clk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_nowrite($sformatf("rstfull_after%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
